// File: rtl/pulse_pair_gen_pkg.sv
// rtl/pulse_pair_gen_pkg.sv - shared state encoding and width default for the pulse pair generator
package pulse_pair_gen_pkg;

  // Default width of the delay and width operands.
  localparam int CNT_W_DEF = 8;

  // FSM encoding; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_pair_gen_meas.sv
// rtl/pulse_pair_gen_meas.sv - measures cycles from the signal1 rise to the signal2 rise
module pulse_pair_gen_meas
  import pulse_pair_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           signal1,
  input  logic           signal2,
  output logic [CNT_W:0] count,
  output logic           valid
);

  localparam logic [CNT_W:0] ONE_T = 1;

  logic           s1_q;
  logic           s2_q;
  logic           armed;
  logic [CNT_W:0] run_cnt;
  logic           s1_rise;
  logic           s2_rise;

  assign s1_rise = signal1 & ~s1_q;
  assign s2_rise = signal2 & ~s2_q;

  // Arm on the signal1 edge, count each following cycle, capture on the signal2 edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      armed   <= 1'b0;
      run_cnt <= '0;
      count   <= '0;
      valid   <= 1'b0;
    end else begin
      s1_q  <= signal1;
      s2_q  <= signal2;
      valid <= 1'b0;
      if (s1_rise && s2_rise) begin
        count <= '0;
        valid <= 1'b1;
        armed <= 1'b0;
      end else if (s1_rise) begin
        armed   <= 1'b1;
        run_cnt <= ONE_T;
      end else if (armed) begin
        if (s2_rise) begin
          count <= run_cnt;
          valid <= 1'b1;
          armed <= 1'b0;
        end else begin
          run_cnt <= run_cnt + ONE_T;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_pair_gen.sv
// rtl/pulse_pair_gen.sv - one-shot generator of a reference pulse and a delayed copy
module pulse_pair_gen
  import pulse_pair_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  output logic             signal1,
  output logic             signal2,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE_W = 1;
  localparam logic [CNT_W:0]   ONE_T = 1;

  state_e           state;
  logic [CNT_W-1:0] d_reg;
  logic [CNT_W-1:0] w_reg;
  logic [CNT_W:0]   t;

  // t is one bit wider than the operands so D+W never wraps.
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W:0]   pair_end;
  logic [CNT_W:0]   t_next;
  logic             last_cycle;

  // Operand conditioning and next-count decode for the running pair.
  always_comb begin
    w_eff      = (width == '0) ? ONE_W : width;
    pair_end   = {1'b0, d_reg} + {1'b0, w_reg};
    t_next     = t + ONE_T;
    last_cycle = (t == (pair_end - ONE_T));
  end

  // Single FSM: outputs are computed from the next value of t so they are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      t       <= '0;
      d_reg   <= '0;
      w_reg   <= '0;
      signal1 <= 1'b0;
      signal2 <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          signal1 <= 1'b0;
          signal2 <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            d_reg   <= delay;
            w_reg   <= w_eff;
            t       <= '0;
            state   <= ST_RUN;
            busy    <= 1'b1;
            // t=0 is always inside the first pulse because W is at least 1.
            signal1 <= 1'b1;
            signal2 <= (delay == '0);
          end
        end

        ST_RUN: begin
          if (last_cycle) begin
            state   <= ST_FIN;
            signal1 <= 1'b0;
            signal2 <= 1'b0;
            done    <= 1'b1;
            t       <= t_next;
          end else begin
            t       <= t_next;
            signal1 <= (t_next < {1'b0, w_reg});
            signal2 <= (t_next >= {1'b0, d_reg}) && (t_next < pair_end);
          end
        end

        ST_FIN: begin
          state   <= ST_IDLE;
          t       <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          signal1 <= 1'b0;
          signal2 <= 1'b0;
        end

        default: begin
          state   <= ST_IDLE;
          t       <= '0;
          busy    <= 1'b0;
          done    <= 1'b0;
          signal1 <= 1'b0;
          signal2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_pair_gen.sv
// tb/tb_pulse_pair_gen.sv - directed self-checking bench for pulse_pair_gen
module tb_pulse_pair_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] delay;
  logic [7:0] width;
  logic       signal1;
  logic       signal2;
  logic       busy;
  logic       done;
  logic [8:0] meas_count;
  logic       meas_valid;

  int n_checks;
  int n_fail;

  pulse_pair_gen #(.CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .delay   (delay),
    .width   (width),
    .signal1 (signal1),
    .signal2 (signal2),
    .busy    (busy),
    .done    (done)
  );

  pulse_pair_gen_meas #(.CNT_W(8)) meas (
    .clk     (clk),
    .reset   (reset),
    .signal1 (signal1),
    .signal2 (signal2),
    .count   (meas_count),
    .valid   (meas_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_s1"}, 32'(signal1), 32'd0);
    check({tag, "_s2"}, 32'(signal2), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Launch a pair from an IDLE cycle and check every cycle through the done cycle.
  // Cycle c counts edges after the start edge: signal1 in [1,W], signal2 in [D+1,D+W],
  // done at D+W+1, busy over [1,D+W+1]. Ends in the first IDLE cycle after done.
  task automatic run_pair(input int d, input int w, input bit perturb);
    int wp;
    int last;
    wp = (w == 0) ? 1 : w;
    last = d + wp + 1;
    start = 1'b1;
    delay = 8'(d);
    width = 8'(w);
    tick();
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      check($sformatf("d%0d_w%0d_c%0d_s1", d, w, c), 32'(signal1), 32'(c >= 1 && c <= wp));
      check($sformatf("d%0d_w%0d_c%0d_s2", d, w, c), 32'(signal2), 32'(c >= d + 1 && c <= d + wp));
      check($sformatf("d%0d_w%0d_c%0d_busy", d, w, c), 32'(busy), 32'd1);
      check($sformatf("d%0d_w%0d_c%0d_done", d, w, c), 32'(done), 32'(c == last));
      if (perturb && c == 2) begin
        start = 1'b1;
        delay = 8'd1;
        width = 8'd1;
      end
      if (perturb && c == 4) start = 1'b0;
      if (c < last) tick();
    end
    tick();
    check_idle($sformatf("d%0d_w%0d_after", d, w));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    start = 1'b0;
    delay = 8'd0;
    width = 8'd0;
    tick();
    tick();
    check_idle("reset");
    check("reset_meas", 32'(meas_count), 32'd0);
    reset = 1'b1;

    // Basic pair, then a back-to-back pair started in the IDLE cycle after done.
    run_pair(9, 5, 1'b0);
    run_pair(6, 9, 1'b0);

    // Smallest operands, width 0 treated as 1.
    run_pair(0, 0, 1'b0);
    check("meas_d0", 32'(meas_count), 32'd0);

    // Largest operands; signal2 must end after t=509 without wrapping.
    run_pair(255, 255, 1'b0);

    // Start and operand changes during RUN are ignored.
    run_pair(9, 5, 1'b1);
    delay = 8'd0;
    width = 8'd0;

    // Reset at t=4 (cycle 5) of a delay=9 width=5 pair.
    start = 1'b1;
    delay = 8'd9;
    width = 8'd5;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("pre_rst_s1", 32'(signal1), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("rst_hold_c%0d_done", c), 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_pair(9, 5, 1'b0);

    // Loopback through the measurement block.
    run_pair(1, 3, 1'b0);
    check("meas_d1", 32'(meas_count), 32'd1);
    run_pair(6, 3, 1'b0);
    check("meas_d6", 32'(meas_count), 32'd6);
    run_pair(9, 3, 1'b0);
    check("meas_d9", 32'(meas_count), 32'd9);
    run_pair(50, 3, 1'b0);
    check("meas_d50", 32'(meas_count), 32'd50);
    run_pair(200, 3, 1'b0);
    check("meas_d200", 32'(meas_count), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
